// File: rtl/axi4_lite_slave_write_ctrl_pkg.sv
// Shared AXI4-Lite write-path types: response codes and controller state encoding.
// No logic; types and constants only.
// Imported by the interface, the controller and its decoder.
package Axi4LiteGlobalsPkg;

  typedef logic [1:0] bresp_t;

  localparam bresp_t RESP_OKAY   = 2'b00;
  localparam bresp_t RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_W  = 3'd1,
    ST_WAIT_AW = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } wr_state_t;

  // Width of a word index for a register file of the given depth (at least 1 bit).
  function automatic int idx_width(input int reg_count);
    return (reg_count > 1) ? $clog2(reg_count) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_write_ctrl_if.sv
// AXI4-Lite write channels (AW, W, B) bundled for the write controller.
// Pure wiring, no latency.
// Backpressure is carried by the ready/valid pairs of each channel.
import Axi4LiteGlobalsPkg::*;

interface axi4_lite_slave_write_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  bresp_t                  bresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi4_lite_slave_write_ctrl_addr_decode.sv
// Byte address to register-file word index, plus an in-range flag.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is consumed.
import Axi4LiteGlobalsPkg::*;

module axi4_lite_wr_addr_decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 16,
  localparam int IDX_W     = idx_width(REG_COUNT)
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [IDX_W-1:0]      o_index,
  output logic                  o_in_range
);
  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  // Full-width word number: any set upper bit must push it out of range,
  // so the range test is done before truncating to the index width.
  logic [ADDR_WIDTH-1:0] w_word;

  assign w_word     = i_addr >> OFF_W;
  assign o_in_range = (w_word < ADDR_WIDTH'(REG_COUNT));
  assign o_index    = w_word[IDX_W-1:0];
endmodule

// File: rtl/axi4_lite_slave_write_ctrl.sv
// AXI4-Lite slave write controller: takes AW and W in either order, writes one register word, answers on B.
// Last of AW/W handshake at edge N -> wr_en during cycle N+1 -> bvalid from cycle N+2.
// One transaction at a time; AW/W ready stay low from the write until the cycle after the B handshake.
// Optional feature macro: AXI4_LITE_SLAVE_WSTRB_EN (pass wstrb through to wr_strb; otherwise full-word writes).
import Axi4LiteGlobalsPkg::*;

module axi4_lite_slave_write_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 16,
  localparam int STRB_W    = DATA_WIDTH / 8,
  localparam int IDX_W     = idx_width(REG_COUNT)
) (
  input  logic                   i_aclk,
  input  logic                   i_areset,
  axi4_lite_slave_write_ctrl_if.slave s_axi,
  output logic                   o_wr_en,
  output logic [IDX_W-1:0]       o_wr_addr,
  output logic [DATA_WIDTH-1:0]  o_wr_data,
  output logic [STRB_W-1:0]      o_wr_strb
);

  wr_state_t               r_state;
  wr_state_t               w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
  logic [STRB_W-1:0]       r_strb;
`endif
  bresp_t                  r_bresp;

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic [IDX_W-1:0]        w_index;
  logic                    w_in_range;

  axi4_lite_wr_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_decode (
    .i_addr     (r_addr),
    .o_index    (w_index),
    .o_in_range (w_in_range)
  );

  // Channel readies from state; forced low while reset is asserted.
  always_comb begin
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    if (!i_areset) begin
      s_axi.awready = (r_state == ST_IDLE) || (r_state == ST_WAIT_AW);
      s_axi.wready  = (r_state == ST_IDLE) || (r_state == ST_WAIT_W);
    end
  end

  assign w_aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_w_hs  = s_axi.wvalid  && s_axi.wready;

  // Next-state: collect AW and W in any order, one write cycle, then wait for B accept.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_aw_hs && w_w_hs) w_next = ST_WRITE;
        else if (w_aw_hs)      w_next = ST_WAIT_W;
        else if (w_w_hs)       w_next = ST_WAIT_AW;
      end
      ST_WAIT_W:  if (w_w_hs)  w_next = ST_WRITE;
      ST_WAIT_AW: if (w_aw_hs) w_next = ST_WRITE;
      ST_WRITE:   w_next = ST_RESP;
      ST_RESP:    if (s_axi.bready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_aclk) begin
    if (i_areset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Capture address/data on their handshakes; readies guarantee each is taken once per transaction.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_addr <= '0;
      r_data <= '0;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
      r_strb <= '0;
`endif
    end else begin
      if (w_aw_hs) r_addr <= s_axi.awaddr;
      if (w_w_hs) begin
        r_data <= s_axi.wdata;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
        r_strb <= s_axi.wstrb;
`endif
      end
    end
  end

  // Latch the response code in the write cycle so B stays stable however long bready is low.
  always_ff @(posedge i_aclk) begin
    if (i_areset)                   r_bresp <= RESP_OKAY;
    else if (r_state == ST_WRITE)   r_bresp <= w_in_range ? RESP_OKAY : RESP_SLVERR;
  end

  // Register-file port and B channel; everything idles at zero outside its own state.
  always_comb begin
    o_wr_en      = 1'b0;
    o_wr_addr    = '0;
    o_wr_data    = '0;
    o_wr_strb    = '0;
    s_axi.bvalid = (r_state == ST_RESP);
    s_axi.bresp  = (r_state == ST_RESP) ? r_bresp : RESP_OKAY;
    if (r_state == ST_WRITE) begin
      o_wr_en   = w_in_range && !i_areset;
      o_wr_addr = w_index;
      o_wr_data = r_data;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
      o_wr_strb = r_strb;
`else
      o_wr_strb = '1;
`endif
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_write_ctrl.sv
// Directed bench for the AXI4-Lite slave write controller.
// Inputs change 2 time units after each rising edge; outputs are sampled at that same point.
// Each scenario task checks its own expectations inline.
module tb_axi4_lite_slave_write_ctrl;
  import Axi4LiteGlobalsPkg::*;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  int          n_cmp;
  int          n_bad;

`ifdef AXI4_LITE_SLAVE_WSTRB_EN
  localparam logic [3:0] EXP_STRB_5 = 4'b0101;
`else
  localparam logic [3:0] EXP_STRB_5 = 4'b1111;
`endif

  axi4_lite_slave_write_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave_write_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .REG_COUNT  (16)
  ) dut (
    .i_aclk    (clk),
    .i_areset  (rst),
    .s_axi     (bus),
    .o_wr_en   (wr_en),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_wr_strb (wr_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.awvalid = 1'b0; bus.awaddr = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); bus.bready = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.awready !== 1'b0) begin n_bad++; $display("FAIL rst_awready: got %b expected 0", bus.awready); end
    n_cmp++; if (bus.wready !== 1'b0) begin n_bad++; $display("FAIL rst_wready: got %b expected 0", bus.wready); end
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_bad++; $display("FAIL rst_bvalid: got %b expected 0", bus.bvalid); end
    n_cmp++; if (bus.bresp !== 2'b00) begin n_bad++; $display("FAIL rst_bresp: got %b expected 00", bus.bresp); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
    n_cmp++; if ({wr_addr, wr_data, wr_strb} !== 40'h0) begin n_bad++; $display("FAIL rst_wr_bus: got %h expected 0", {wr_addr, wr_data, wr_strb}); end
    rst = 1'b0; #1;
    n_cmp++; if ({bus.awready, bus.wready} !== 2'b11) begin n_bad++; $display("FAIL rst_release_ready: got %b expected 11", {bus.awready, bus.wready}); end
  endtask

  task automatic test_simultaneous();
    bus.awvalid = 1'b1; bus.awaddr = 32'h0000_0008;
    bus.wvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.bready = 1'b1;
    tick(); idle_inputs();
    n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL sim_wr_en: got %b expected 1", wr_en); end
    n_cmp++; if (wr_addr !== 4'd2) begin n_bad++; $display("FAIL sim_wr_addr: got %0d expected 2", wr_addr); end
    n_cmp++; if (wr_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sim_wr_data: got %h expected deadbeef", wr_data); end
    n_cmp++; if (wr_strb !== 4'hF) begin n_bad++; $display("FAIL sim_wr_strb: got %h expected f", wr_strb); end
    n_cmp++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b000) begin n_bad++; $display("FAIL sim_write_flags: got %b expected 000", {bus.bvalid, bus.awready, bus.wready}); end
    tick();
    n_cmp++; if ({bus.bvalid, bus.bresp} !== 3'b100) begin n_bad++; $display("FAIL sim_b: got %b expected 100", {bus.bvalid, bus.bresp}); end
    n_cmp++; if ({wr_en, wr_data} !== 33'h0) begin n_bad++; $display("FAIL sim_resp_wr_idle: got %h expected 0", {wr_en, wr_data}); end
    tick();
    n_cmp++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin n_bad++; $display("FAIL sim_back_idle: got %b expected 011", {bus.bvalid, bus.awready, bus.wready}); end
  endtask

  task automatic test_aw_first();
    bus.awvalid = 1'b1; bus.awaddr = 32'h0000_0004; bus.bready = 1'b1;
    tick(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({bus.awready, bus.wready, wr_en} !== 3'b010) begin n_bad++; $display("FAIL awf_wait_%0d: got %b expected 010", i, {bus.awready, bus.wready, wr_en}); end
      if (i < 2) tick();
    end
    bus.wvalid = 1'b1; bus.wdata = 32'h1234_5678; bus.wstrb = 4'b0101;
    tick(); idle_inputs();
    n_cmp++; if ({wr_en, wr_addr} !== 5'b1_0001) begin n_bad++; $display("FAIL awf_write: got %b expected 10001", {wr_en, wr_addr}); end
    n_cmp++; if (wr_data !== 32'h1234_5678) begin n_bad++; $display("FAIL awf_wr_data: got %h expected 12345678", wr_data); end
    n_cmp++; if (wr_strb !== EXP_STRB_5) begin n_bad++; $display("FAIL awf_wr_strb: got %b expected %b", wr_strb, EXP_STRB_5); end
    tick();
    n_cmp++; if ({bus.bvalid, bus.bresp} !== 3'b100) begin n_bad++; $display("FAIL awf_b: got %b expected 100", {bus.bvalid, bus.bresp}); end
    tick();
  endtask

  task automatic test_w_first_out_of_range();
    bus.wvalid = 1'b1; bus.wdata = 32'hCAFE_0001; bus.wstrb = 4'hF; bus.bready = 1'b1;
    tick(); idle_inputs();
    n_cmp++; if ({bus.awready, bus.wready} !== 2'b10) begin n_bad++; $display("FAIL wf_wait: got %b expected 10", {bus.awready, bus.wready}); end
    bus.awvalid = 1'b1; bus.awaddr = 32'h0000_0100;
    tick(); idle_inputs();
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL wf_oor_wr_en: got %b expected 0", wr_en); end
    tick();
    n_cmp++; if ({bus.bvalid, bus.bresp} !== 3'b110) begin n_bad++; $display("FAIL wf_oor_b: got %b expected 110", {bus.bvalid, bus.bresp}); end
    tick();
  endtask

  task automatic test_boundaries();
    logic [31:0] addrs [4];
    logic        exp_en [4];
    logic [3:0]  exp_idx [4];
    addrs = '{32'h0000_003C, 32'h0000_0040, 32'h8000_0004, 32'h0000_000B};
    exp_en = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_idx = '{4'd15, 4'd0, 4'd0, 4'd2};
    bus.bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.awvalid = 1'b1; bus.awaddr = addrs[i];
      bus.wvalid = 1'b1; bus.wdata = 32'h0000_1000 + i; bus.wstrb = 4'hF;
      tick(); idle_inputs();
      n_cmp++; if (wr_en !== exp_en[i]) begin n_bad++; $display("FAIL bnd_wr_en_%0d: got %b expected %b", i, wr_en, exp_en[i]); end
      if (exp_en[i]) begin
        n_cmp++; if (wr_addr !== exp_idx[i]) begin n_bad++; $display("FAIL bnd_wr_addr_%0d: got %0d expected %0d", i, wr_addr, exp_idx[i]); end
      end
      tick();
      n_cmp++; if (bus.bresp !== (exp_en[i] ? 2'b00 : 2'b10)) begin n_bad++; $display("FAIL bnd_bresp_%0d: got %b expected %b", i, bus.bresp, exp_en[i] ? 2'b00 : 2'b10); end
      tick();
    end
  endtask

  task automatic test_bready_stall();
    bus.awvalid = 1'b1; bus.awaddr = 32'h0000_000C;
    bus.wvalid = 1'b1; bus.wdata = 32'hA5A5_0F0F; bus.wstrb = 4'hF; bus.bready = 1'b0;
    tick(); idle_inputs();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b10000) begin n_bad++; $display("FAIL stall_%0d: got %b expected 10000", i, {bus.bvalid, bus.bresp, bus.awready, bus.wready}); end
      tick();
    end
    bus.bready = 1'b1;
    n_cmp++; if ({bus.bvalid, bus.awready} !== 2'b10) begin n_bad++; $display("FAIL stall_release: got %b expected 10", {bus.bvalid, bus.awready}); end
    tick();
    n_cmp++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin n_bad++; $display("FAIL stall_after_b: got %b expected 011", {bus.bvalid, bus.awready, bus.wready}); end
  endtask

  task automatic test_reset_mid();
    bus.awvalid = 1'b1; bus.awaddr = 32'h0000_0008; bus.bready = 1'b1;
    tick(); idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    n_cmp++; if ({bus.awready, bus.wready, bus.bvalid, wr_en} !== 4'b1100) begin n_bad++; $display("FAIL mid_rst: got %b expected 1100", {bus.awready, bus.wready, bus.bvalid, wr_en}); end
    bus.wvalid = 1'b1; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF;
    tick(); idle_inputs();
    n_cmp++; if ({bus.awready, bus.wready, wr_en} !== 3'b100) begin n_bad++; $display("FAIL mid_addr_dropped: got %b expected 100", {bus.awready, bus.wready, wr_en}); end
    bus.awvalid = 1'b1; bus.awaddr = 32'h0000_0014;
    tick(); idle_inputs();
    n_cmp++; if ({wr_en, wr_addr} !== 5'b1_0101) begin n_bad++; $display("FAIL mid_write: got %b expected 10101", {wr_en, wr_addr}); end
    n_cmp++; if (wr_data !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL mid_wr_data: got %h expected 0badf00d", wr_data); end
    tick();
    n_cmp++; if ({bus.bvalid, bus.bresp} !== 3'b100) begin n_bad++; $display("FAIL mid_b: got %b expected 100", {bus.bvalid, bus.bresp}); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.bready = 1'b0;
    idle_inputs();
    test_reset();
    test_simultaneous();
    test_aw_first();
    test_w_first_out_of_range();
    test_boundaries();
    test_bready_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
